// File: rtl/sd_spi_cmd_if.sv
// Host-side request/response bundle of the SD SPI command engine.
interface sd_spi_cmd_if;
    logic        start;
    logic [5:0]  command;
    logic [31:0] arg;
    logic        resp_long;
    logic        busy;
    logic [39:0] response;
    logic        response_ready;
    logic        timeout;

    // start is a one-cycle request taken only while the engine is idle; each taken start
    // yields exactly one response_ready pulse, and response/timeout hold until the next taken start.
    modport master (
        output start, command, arg, resp_long,
        input  busy, response, response_ready, timeout
    );
    modport slave (
        input  start, command, arg, resp_long,
        output busy, response, response_ready, timeout
    );
endinterface

// File: rtl/sd_spi_cmd.sv
// SD-card SPI-mode command engine: frames CMD+arg+CRC7, sends it in SPI mode 0,
// polls for the response start bit with a byte-count timeout and captures an R1 or R3/R7 reply.
module sd_spi_cmd #(
    parameter int CLK_DIV      = 2,
    parameter int RESP_TIMEOUT = 8,
    parameter bit CRC_EN       = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    sd_spi_cmd_if.slave      bus,
    input  logic             miso,
    output logic             mosi,
    output logic             sdclk,
    output logic             sd_chip_select,
    output logic [3:0]       state_out
);
    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_CS_ASSERT = 4'd1,
        S_SEND      = 4'd2,
        S_POLL      = 4'd3,
        S_RECV      = 4'd4,
        S_DESELECT  = 4'd5,
        S_DONE      = 4'd6
    } state_t;

    localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
    localparam logic [15:0] POLL_LAST = 16'(8 * RESP_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [15:0] div_q, div_d;
    logic        sdclk_q, sdclk_d;
    logic [15:0] bit_q, bit_d;
    logic [47:0] frame_q, frame_d;
    logic [39:0] resp_q, resp_d;
    logic        timeout_q, timeout_d;
    logic        long_q, long_d;
    logic        found_q, found_d;

    logic        active;
    logic        tick;
    logic        rise;
    logic        fall;
    logic        accept;
    logic [15:0] recv_last;
    logic [39:0] cmd_msg;
    logic [7:0]  last_byte;
    logic        mosi_c;
    logic        cs_c;
    logic        busy_c;

    // CRC7 with polynomial x^7 + x^3 + 1, seed 0, MSB-first over the 40 header bits.
    function automatic logic [6:0] crc7(input logic [39:0] msg);
        logic [6:0] c;
        logic       fb;
        c = 7'd0;
        for (int i = 39; i >= 0; i--) begin
            fb = c[6] ^ msg[i];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    assign active    = (state_q != S_IDLE) && (state_q != S_DONE);
    assign tick      = active && (div_q == DIV_LAST);
    assign rise      = tick && !sdclk_q;
    assign fall      = tick && sdclk_q;
    assign accept    = (state_q == S_IDLE) && bus.start;
    assign recv_last = long_q ? 16'd38 : 16'd6;
    assign cmd_msg   = {2'b01, bus.command, bus.arg};
    assign last_byte = CRC_EN ? {crc7(cmd_msg), 1'b1} : 8'hFF;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: every bit-phase transition happens on an sdclk falling edge, so sdclk
    // is low at each boundary and no partial pulse can be emitted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (bus.start) state_d = S_CS_ASSERT;
            S_CS_ASSERT: if (fall && bit_q == 16'd7) state_d = S_SEND;
            S_SEND:      if (fall && bit_q == 16'd47) state_d = S_POLL;
            S_POLL: begin
                if (fall && found_q) begin
                    state_d = S_RECV;
                end else if (fall && bit_q == POLL_LAST) begin
                    state_d = S_DESELECT;
                end
            end
            S_RECV:      if (fall && bit_q == recv_last) state_d = S_DESELECT;
            S_DESELECT:  if (fall && bit_q == 16'd7) state_d = S_DONE;
            S_DONE:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the registered state.
    always_comb begin
        mosi_c = 1'b1;
        cs_c   = 1'b1;
        busy_c = 1'b0;
        case (state_q)
            S_CS_ASSERT, S_POLL, S_RECV: begin
                cs_c   = 1'b0;
                busy_c = 1'b1;
            end
            S_SEND: begin
                cs_c   = 1'b0;
                busy_c = 1'b1;
                mosi_c = frame_q[47];
            end
            S_DESELECT: busy_c = 1'b1;
            default: ;
        endcase
    end

    // Datapath next values: clock divider, bit counter, frame shifter and response capture.
    always_comb begin
        div_d     = div_q;
        sdclk_d   = sdclk_q;
        bit_d     = bit_q;
        frame_d   = frame_q;
        resp_d    = resp_q;
        timeout_d = timeout_q;
        long_d    = long_q;
        found_d   = found_q;

        if (active) begin
            div_d = (div_q == DIV_LAST) ? 16'd0 : div_q + 16'd1;
            if (div_q == DIV_LAST) sdclk_d = ~sdclk_q;
        end else begin
            div_d   = 16'd0;
            sdclk_d = 1'b0;
        end

        if (fall) bit_d = (state_d != state_q) ? 16'd0 : bit_q + 16'd1;

        if (accept) begin
            frame_d   = {cmd_msg, last_byte};
            resp_d    = 40'd0;
            timeout_d = 1'b0;
            long_d    = bus.resp_long;
            found_d   = 1'b0;
            bit_d     = 16'd0;
        end

        if (state_q == S_SEND && fall) frame_d = {frame_q[46:0], 1'b1};

        // The first 0 seen while polling is the response MSB, at any bit position.
        if (state_q == S_POLL && rise && !miso && !found_q) begin
            resp_d  = 40'd0;
            found_d = 1'b1;
        end
        if (state_q == S_POLL && fall && !found_q && bit_q == POLL_LAST) begin
            resp_d    = '1;
            timeout_d = 1'b1;
        end

        if (state_q == S_RECV && rise) resp_d = {resp_q[38:0], miso};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q     <= 16'd0;
            sdclk_q   <= 1'b0;
            bit_q     <= 16'd0;
            frame_q   <= '1;
            resp_q    <= 40'd0;
            timeout_q <= 1'b0;
            long_q    <= 1'b0;
            found_q   <= 1'b0;
        end else begin
            div_q     <= div_d;
            sdclk_q   <= sdclk_d;
            bit_q     <= bit_d;
            frame_q   <= frame_d;
            resp_q    <= resp_d;
            timeout_q <= timeout_d;
            long_q    <= long_d;
            found_q   <= found_d;
        end
    end

    assign mosi               = mosi_c;
    assign sd_chip_select     = cs_c;
    assign sdclk              = sdclk_q;
    assign state_out          = state_q;
    assign bus.busy           = busy_c;
    assign bus.response       = resp_q;
    assign bus.response_ready = (state_q == S_DONE);
    assign bus.timeout        = timeout_q;
endmodule

// File: doc/sd_spi_cmd.md
Name: sd_spi_cmd

Overview:
Parametrised SD-card SPI-mode command engine, successor to the fixed sd_test block.
- Accepts a 6-bit command index and 32-bit argument on a start strobe.
- Frames the 48-bit command with a generated CRC7, clocks it out, polls for the response start bit with a timeout, and captures either an R1 (8-bit) or R3/R7 (40-bit) response.
- Sits between the frame-streaming controller and the SD card pins.

Parameters:
CLK_DIV, 2, clk cycles per sdclk half-period (legal values 1 and up).
RESP_TIMEOUT, 8, maximum bytes (8 sdclk each) polled for the response start bit.
CRC_EN, 1, 1 = compute CRC7; 0 = use fixed byte 0xFF as last byte.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  one-cycle request; sampled only in IDLE
command  in  6  command index; captured on accepted start
arg  in  32  command argument; captured on accepted start
resp_long  in  1  captured on start; 1 = 40-bit response, 0 = 8-bit R1
busy  out  1  high from the cycle after an accepted start until back in IDLE
response  out  40  captured response, right-aligned, upper bits zero for R1
response_ready  out  1  one-cycle pulse when response/timeout is valid
timeout  out  1  valid with response_ready, held until next accepted start
miso  in  1  card data out
mosi  out  1  card data in
sdclk  out  1  SPI clock, mode 0
sd_chip_select  out  1  active-low card select
state_out  out  4  current FSM state encoding

Behaviour:
- Reset values: sdclk=0, mosi=1, sd_chip_select=1, busy=0, response=0, response_ready=0, timeout=0, state_out=0.
- Reset mid-operation returns all outputs to reset values on the next edge. No partial response is reported.
- SPI mode 0:
  - sdclk idles low. Period is 2*CLK_DIV clk cycles.
  - mosi changes only on sdclk falling edges or while sdclk is low.
  - miso is sampled in the clk cycle where sdclk rises.
- Frame, sent MSB-first, 48 bits:
  - Byte 0: {2'b01, command}.
  - Bytes 1-4: arg[31:24] down to arg[7:0].
  - Byte 5: {crc7, 1'b1}.
  - crc7 uses polynomial x^7+x^3+1, initial value 0, computed over bytes 0-4.
  - Checks: CMD0/arg 0 gives 0x95; CMD8/arg 0x1AA gives 0x87.
- FSM states (state_out):
  - IDLE=0: waits for start. start when not IDLE is ignored.
  - CS_ASSERT=1: sd_chip_select=0, mosi=1, 8 sdclk cycles of preamble.
  - SEND=2: 48 command bits.
  - POLL=3: mosi=1. Each sampled miso bit is checked. The first 0 bit is the response MSB; it is stored and the FSM goes to RECV.
    - After 8*RESP_TIMEOUT sampled bits with no 0 bit: response=40'hFF_FFFF_FFFF, timeout=1, go to DESELECT.
    - The start bit need not be byte-aligned.
  - RECV=4: mosi=1. Captures a further 7 bits (resp_long=0) or 39 bits (resp_long=1), shifting into response LSB.
  - DESELECT=5: sd_chip_select=1, mosi=1, 8 further sdclk cycles.
  - DONE=6: response_ready=1 for exactly one cycle, busy=0 in the same cycle, then IDLE.
- sdclk is low at every state boundary. No partial sdclk pulse is ever emitted.
- Latency from start to response_ready, with P the number of polled bits before the start bit:
  1 + (8 + 48 + P + 8 or 40 + 8) * 2*CLK_DIV + 1 clk.
- A start asserted in the DONE cycle is ignored. It is accepted only when IDLE is seen on the next cycle.
- timeout and response hold their values until the next accepted start clears them.

Test Plan:
- CMD0, arg 0, resp_long=0, CLK_DIV=2: mosi bytes 40 00 00 00 00 95. Card drives FF FF then 01. Expect response=40'h00_0000_0001, timeout=0, one response_ready pulse, sd_chip_select high afterwards.
- CMD8, arg 32'h1AA, resp_long=1: last byte 0x87. Card returns 01 00 00 01 AA. Expect response=40'h01_0000_01AA.
- miso held 1, RESP_TIMEOUT=8: exactly 64 polled sdclk cycles, then timeout=1, response=40'hFF_FFFF_FFFF, state passes through 5 and 6 to 0.
- Unaligned start bit: miso goes low on the 4th polled bit and the card sends 0x05 from that bit. Expect response=40'h05.
- start pulsed during SEND: ignored, frame unchanged. rst asserted mid-SEND: next cycle sd_chip_select=1, sdclk=0, mosi=1, state_out=0, busy=0, no response_ready.
- CLK_DIV=1 and CLK_DIV=4: measured sdclk period is 2 and 8 clk. Total latency matches the formula to the exact cycle.
